// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_subtractor_pkg;

  // Operation phases: waiting for start, shifting one bit per cycle, and
  // the single-cycle result-valid phase.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes A - B - bin and the outgoing borrow.
// Purely combinational.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // A borrow leaves this bit when B exceeds A, or when they match and a
  // borrow came in from the bit below.
  always_comb begin
    diff = A ^ B ^ bin;
    bout = (~A & B) | (~(A ^ B) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B modulo 2^WIDTH one bit per clock,
// LSB first, through a single full_subtractor cell.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the signed
// overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  // The counter gets one spare bit so it can represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             bitdiff;
  logic             bitborrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             amsb;
  logic             bmsb;
`endif

  full_subtractor u_cell (
    .A    (areg[0]),
    .B    (breg[0]),
    .bin  (borrow),
    .diff (bitdiff),
    .bout (bitborrow)
  );

  // Sequencer: capture operands on start, shift WIDTH bits through the cell,
  // then publish done/bout for one cycle before returning to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      borrow <= 1'b0;
      count  <= '0;
      areg   <= '0;
      breg   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
      amsb   <= 1'b0;
      bmsb   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg   <= A;
            breg   <= B;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            amsb   <= A[WIDTH-1];
            bmsb   <= B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          diff   <= {bitdiff, diff[WIDTH-1:1]};
          areg   <= areg >> 1;
          breg   <= breg >> 1;
          borrow <= bitborrow;
          count  <= count + 1'b1;
          if (count == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          bout  <= borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf   <= (amsb != bmsb) && (diff[WIDTH-1] != amsb);
`endif
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  minuend, captured on the accepted start.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (SHIFT state).
REQ-008 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port diff  output  WIDTH  result A-B modulo 2^WIDTH, held until the next accepted start.
REQ-010 SHALL have port bout  output  1  final borrow (1 when A<B unsigned), held with diff.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: start=1 -> capture A, B into shift registers, clear borrow, clear bit counter, go to SHIFT; start=0 -> stay.
REQ-013 SHIFT: each cycle compute one bit LSB-first: d = a0^b0^br, br_next = (~a0&b0) | (~(a0^b0)&br); shift d into diff MSB side; increment counter.
REQ-014 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-015 DONE: done=1 for exactly one cycle, bout = final borrow, then unconditionally go to IDLE.
REQ-016 Latency: done SHALL assert WIDTH+1 cycles after the edge that accepted start; next start accepted the cycle after done.
REQ-017 start while busy or in DONE SHALL be ignored; A/B changes after acceptance SHALL not affect the result.
REQ-018 diff and bout SHALL be invalid (undefined value permitted but stable-shifting) during SHIFT and valid from the done cycle until the next accepted start.
REQ-019 Boundaries: A==B -> diff=0, bout=0; A=0,B=1 -> diff=all ones, bout=1; B=0 -> diff=A, bout=0.
REQ-020 Bit counter SHALL be sized $clog2(WIDTH)+1 bits and SHALL not wrap within an operation.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, done=0, diff=0, bout=0, borrow=0, counter=0.
REQ-022 rst asserted mid-operation SHALL abort it with no done pulse; first start after release begins a fresh operation.

Configuration
REQ-023 Macro SERIAL_SUBTRACTOR_OVF_EN defined: SHALL add output ovf (1 bit) = signed two's-complement overflow, i.e. (A[MSB]!=B[MSB]) && (diff[MSB]!=A[MSB]), valid and held with diff, reset to 0.
REQ-024 Macro undefined: port ovf and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-025 A shared package/header serial_subtractor_pkg SHALL hold the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH constant.
REQ-026 The per-bit arithmetic SHALL be a sub-module full_subtractor (inputs A, B, bin; outputs diff, bout), purely combinational, instantiated once.

Verification
REQ-027 WIDTH=8, A=8'd200, B=8'd55, start pulse -> done after 9 cycles, diff=8'd145, bout=0, busy high 8 cycles.
REQ-028 A=8'd0, B=8'd1 -> diff=8'hFF, bout=1; with OVF_EN ovf=0.
REQ-029 OVF_EN: A=8'h80, B=8'h01 -> diff=8'h7F, bout=0, ovf=1; A=B=8'h5A -> diff=0, bout=0, ovf=0.
REQ-030 start held high continuously with A=8'd10,B=8'd3 -> back-to-back operations, done every 10 cycles, diff=8'd7 each time; A/B changed mid-SHIFT to 8'd1 -> result still 8'd7.
REQ-031 rst pulsed at SHIFT cycle 4 -> busy=0, diff=0, no done; subsequent A=8'd9,B=8'd9 -> diff=0, bout=0 after 9 cycles.
